// File: rtl/axi_lite_master_cmd.sv
// axi_lite_master_cmd: single-outstanding AXI4-Lite master engine.
// A command (read or write) is accepted on a valid/ready port, the matching
// AXI4-Lite handshakes are run, and the slave's data/response code is returned
// on a valid/ready response port. Every output is a flop.
// Optional build macro AXI_M_TIMEOUT_EN adds a per-phase watchdog of
// TIMEOUT_CYCLES cycles that aborts the transaction with response 2'b10.
module axi_lite_master_cmd #(
    parameter int C_DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    // command port
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response port
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_rnw,
    output logic [C_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                  rsp_resp,
    // write address channel
    output logic [ADDR_WIDTH-1:0]       awaddr,
    output logic [2:0]                  awprot,
    output logic                        awvalid,
    input  logic                        awready,
    // write data channel
    output logic [C_DATA_WIDTH-1:0]     wdata,
    output logic [C_DATA_WIDTH/8-1:0]   wstrb,
    output logic                        wvalid,
    input  logic                        wready,
    // write response channel
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0]       araddr,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    // read data channel
    input  logic [C_DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t state_r;
    logic   aw_done_r;
    logic   w_done_r;

    // Handshakes complete on the edge where both valid and ready are high;
    // the valids/readies on our side are flops, so these are glitch-free.
    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, rsp_hs_s, wr_both_s;
    logic timeout_hit_s;

    assign aw_hs_s   = awvalid & awready;
    assign w_hs_s    = wvalid & wready;
    assign b_hs_s    = bvalid & bready;
    assign ar_hs_s   = arvalid & arready;
    assign r_hs_s    = rvalid & rready;
    assign rsp_hs_s  = rsp_valid & rsp_ready;
    // Address and data may be accepted together or in either order.
    assign wr_both_s = (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);

    // Protection attributes are fixed: unprivileged, secure, data access.
    assign awprot = 3'b000;
    assign arprot = 3'b000;

`ifdef AXI_M_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_r;
    logic          waiting_s;
    logic          advance_s;

    assign waiting_s = (state_r == WR_REQ) | (state_r == WR_RESP) |
                       (state_r == RD_REQ) | (state_r == RD_DATA);
    // A phase that makes progress this cycle never times out; the counter
    // restarts from zero in the phase that follows.
    assign advance_s = ((state_r == WR_REQ)  & wr_both_s) |
                       ((state_r == WR_RESP) & b_hs_s)    |
                       ((state_r == RD_REQ)  & ar_hs_s)   |
                       ((state_r == RD_DATA) & r_hs_s);
    // Fires on the TIMEOUT_CYCLES-th cycle spent waiting in one phase.
    assign timeout_hit_s = waiting_s & ~advance_s &
                           (timer_r == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles in the current slave-wait phase, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {TW{1'b0}};
        end else if (!waiting_s || advance_s || timeout_hit_s) begin
            timer_r <= {TW{1'b0}};
        end else begin
            timer_r <= timer_r + TW'(1'b1);
        end
    end
`else
    // Without the watchdog the engine waits on the slave indefinitely.
    assign timeout_hit_s = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Transaction sequencer: one outstanding command, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rnw   <= 1'b0;
            rsp_rdata <= {C_DATA_WIDTH{1'b0}};
            rsp_resp  <= 2'b00;
            awaddr    <= {ADDR_WIDTH{1'b0}};
            awvalid   <= 1'b0;
            wdata     <= {C_DATA_WIDTH{1'b0}};
            wstrb     <= {(C_DATA_WIDTH/8){1'b0}};
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= {ADDR_WIDTH{1'b0}};
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_rnw   <= cmd_rnw;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (cmd_rnw) begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state_r <= RD_REQ;
                        end else begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state_r <= WR_REQ;
                        end
                    end else begin
                        // First IDLE cycle after reset raises ready.
                        cmd_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (aw_hs_s) begin
                        awvalid   <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid   <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (wr_both_s) begin
                        bready  <= 1'b1;
                        state_r <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs_s) begin
                        rsp_resp  <= bresp;
                        rsp_rdata <= {C_DATA_WIDTH{1'b0}};
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= RSP;
                    end
                end
                RD_REQ: begin
                    if (ar_hs_s) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs_s) begin
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_r   <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_hs_s) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    awvalid   <= 1'b0;
                    wvalid    <= 1'b0;
                    bready    <= 1'b0;
                    arvalid   <= 1'b0;
                    rready    <= 1'b0;
                end
            endcase

            // Watchdog abort overrides the phase logic above; it can only
            // fire in a cycle where that phase made no progress.
            if (timeout_hit_s) begin
                awvalid   <= 1'b0;
                wvalid    <= 1'b0;
                bready    <= 1'b0;
                arvalid   <= 1'b0;
                rready    <= 1'b0;
                rsp_resp  <= 2'b10;
                rsp_rdata <= {C_DATA_WIDTH{1'b0}};
                rsp_valid <= 1'b1;
                state_r   <= RSP;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Self-checking bench for axi_lite_master_cmd. The bench plays the AXI4-Lite
// slave (a 4-word register file) and the command/response client, and keeps
// a separate reference register file updated from the commands themselves.
module tb_axi_lite_master_cmd;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_rnw;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] slave_mem [4];
    logic [DW-1:0] model_mem [4];

    always #5 clk = ~clk;

    axi_lite_master_cmd #(
        .C_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rnw(rsp_rnw),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_slave;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    // One command end to end. Delays count cycles each valid is seen before
    // the bench raises the matching ready / response valid.
    task automatic run_txn(input bit rnw, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                           input int ar_d, input int r_d, input int rsp_d, input logic [1:0] sresp);
        bit accepted = 0, aw_got = 0, w_got = 0, b_got = 0, ar_got = 0, r_got = 0;
        bit wrote = 0, done = 0, seen = 0;
        bit late = 0, unstable = 0, proto = 0, crdy_bad = 0, lat_ok = 0;
        bit cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
        int acc_step = -10;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
        int aw_n = 0, w_n = 0, ar_n = 0;
        logic [3:0]  c_awaddr = 4'h0, c_araddr = 4'h0, c_wstrb = 4'h0;
        logic [31:0] c_wdata = 32'h0;
        logic        o_rnw = 1'b0;
        logic [1:0]  o_resp = 2'b00;
        logic [31:0] o_rdata = 32'h0;
        logic [31:0] exp_rdata;

        exp_rdata = rnw ? model_mem[addr[3:2]] : 32'h0;
        cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;

        for (int step = 0; step < 200 && !done; step++) begin
            cmd_valid = !accepted;
            if (accepted && cmd_ready) crdy_bad = 1;
            if (accepted && step == acc_step + 1)
                lat_ok = rnw ? (arvalid && !awvalid && !wvalid) : (awvalid && wvalid && !arvalid);

            awready = 1'b0;
            if (awvalid) begin
                if (aw_got || rnw) late = 1;
                if (awaddr !== addr) unstable = 1;
                awready = (aw_cnt >= aw_d); aw_cnt++;
            end
            wready = 1'b0;
            if (wvalid) begin
                if (w_got || rnw) late = 1;
                if (wdata !== wd || wstrb !== ws) unstable = 1;
                wready = (w_cnt >= w_d); w_cnt++;
            end
            bvalid = 1'b0; bresp = 2'($urandom);
            if (aw_got && w_got && !b_got) begin
                if (b_cnt >= b_d) begin bvalid = 1'b1; bresp = sresp; end
                b_cnt++;
            end
            if (bready && !(aw_got && w_got && !b_got)) proto = 1;

            arready = 1'b0;
            if (arvalid) begin
                if (ar_got || !rnw) late = 1;
                if (araddr !== addr) unstable = 1;
                arready = (ar_cnt >= ar_d); ar_cnt++;
            end
            rvalid = 1'b0; rresp = 2'($urandom); rdata = $urandom;
            if (ar_got && !r_got) begin
                if (r_cnt >= r_d) begin
                    rvalid = 1'b1; rresp = sresp; rdata = slave_mem[c_araddr[3:2]];
                end
                r_cnt++;
            end
            if (rready && !(ar_got && !r_got)) proto = 1;

            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (!(rnw ? r_got : b_got)) proto = 1;
                if (!seen) begin
                    seen = 1; o_rnw = rsp_rnw; o_resp = rsp_resp; o_rdata = rsp_rdata;
                end else if ({rsp_rnw, rsp_resp, rsp_rdata} !== {o_rnw, o_resp, o_rdata}) begin
                    unstable = 1;
                end
                rsp_ready = (rsp_cnt >= rsp_d); rsp_cnt++;
            end

            cmd_hs = cmd_valid && cmd_ready;
            aw_hs  = awvalid && awready;
            w_hs   = wvalid && wready;
            b_hs   = bvalid && bready;
            ar_hs  = arvalid && arready;
            r_hs   = rvalid && rready;
            rsp_hs = rsp_valid && rsp_ready;
            if (aw_hs) c_awaddr = awaddr;
            if (w_hs) begin c_wdata = wdata; c_wstrb = wstrb; end
            if (ar_hs) c_araddr = araddr;

            tick;

            if (cmd_hs) begin accepted = 1; acc_step = step; end
            if (aw_hs) begin aw_got = 1; aw_n++; end
            if (w_hs)  begin w_got = 1; w_n++; end
            if (ar_hs) begin ar_got = 1; ar_n++; end
            if (b_hs) b_got = 1;
            if (r_hs) r_got = 1;
            if (aw_got && w_got && !wrote) begin
                wrote = 1;
                for (int b = 0; b < SW; b++)
                    if (c_wstrb[b]) slave_mem[c_awaddr[3:2]][8*b +: 8] = c_wdata[8*b +: 8];
            end
            if (rsp_hs) done = 1;
        end
        idle_slave();

        check("txn_done", 64'(done), 64'd1);
        check("rsp_rnw", 64'(o_rnw), 64'(rnw));
        check("rsp_rdata", 64'(o_rdata), 64'(exp_rdata));
        check("rsp_resp", 64'(o_resp), 64'(sresp));
        check("valid_latency", 64'(lat_ok), 64'd1);
        check("stable_fields", 64'(unstable), 64'd0);
        check("valid_after_hs", 64'(late), 64'd0);
        check("ready_protocol", 64'(proto), 64'd0);
        check("cmd_ready_busy", 64'(crdy_bad), 64'd0);
        check("hs_counts", 64'({aw_n[3:0], w_n[3:0], ar_n[3:0]}),
              rnw ? 64'h001 : 64'h110);
        check("valid_hold", 64'(rnw ? ar_cnt : (aw_cnt * 16 + w_cnt)),
              64'(rnw ? (ar_d + 1) : ((aw_d + 1) * 16 + w_d + 1)));
        check("cmd_ready_after", 64'({cmd_ready, rsp_valid}), 64'b10);
        if (!rnw) begin
            check("wr_fields", 64'({c_awaddr, c_wstrb, c_wdata}), 64'({addr, ws, wd}));
            for (int b = 0; b < SW; b++)
                if (ws[b]) model_mem[addr[3:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_rnw = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        idle_slave();
        for (int i = 0; i < 4; i++) begin
            slave_mem[i] = $urandom;
            model_mem[i] = slave_mem[i];
        end
        tick; tick;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
        check("rst_rsp", 64'({rsp_rnw, rsp_resp, rsp_rdata}), 64'd0);
        check("rst_paths", 64'({awaddr, araddr, wdata, wstrb}), 64'd0);
        check("prot", 64'({awprot, arprot}), 64'd0);
        rst = 1'b0;
        tick;
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Directed: plain write, slow AW, preloaded read, slow consumer, error pass-through.
        run_txn(1'b0, 4'h4, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
        run_txn(1'b0, 4'h0, 32'hA5A5_1234, 4'hF, 3, 0, 0, 0, 0, 0, 2'b00);
        slave_mem[2] = 32'h0000_0011; model_mem[2] = 32'h0000_0011;
        run_txn(1'b1, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);
        run_txn(1'b1, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1, 2, 5, 2'b00);
        run_txn(1'b1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b10);
        run_txn(1'b0, 4'hC, 32'hCAFE_F00D, 4'b0101, 0, 2, 1, 0, 0, 1, 2'b00);
        run_txn(1'b0, 4'h8, 32'h7777_7777, 4'hF, 0, 0, 0, 0, 0, 0, 2'b11);
        run_txn(1'b1, 4'hC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b01);

        // Slave never accepts the write address.
        cmd_rnw = 1'b0; cmd_addr = 4'hC; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        check("stuck_awvalid", 64'(awvalid), 64'd1);
`ifdef AXI_M_TIMEOUT_EN
        begin
            int k;
            k = 1;
            while (!rsp_valid && k < 64) begin tick; k++; end
            check("timeout_cycles", 64'(k), 64'(TO + 1));
            check("timeout_rsp", 64'({rsp_resp, rsp_rdata}), 64'({2'b10, 32'h0}));
            check("timeout_valids", 64'({awvalid, wvalid, bready}), 64'd0);
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
            check("timeout_cmd_ready", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b1;
            tick;
            cmd_valid = 1'b0;
            tick; tick;
        end
`else
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 40; k++) begin
                tick;
                if (rsp_valid) got = 1;
            end
            check("no_rsp_without_timeout", 64'(got), 64'd0);
        end
`endif
        check("wr_req_before_rst", 64'({awvalid, wvalid}), 64'b11);
        rst = 1'b1;
        tick;
        check("rst_mid_valids",
              64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}), 64'd0);
        rst = 1'b0;
        tick;
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);

        // Randomized traffic against the reference register file.
        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
                    2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
